// File: rtl/bnn_pkg.sv
// Shared types and widths for the binarised-network datapath.
package bnn_pkg;

    localparam int unsigned ACC_W = 11;
    localparam int unsigned ACT_W = 16;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic [ACT_W-1:0] act_t;

    typedef enum logic [1:0] {IDLE, PACK, DRAIN} pack_state_t;

    // 1 encodes +1, 0 encodes -1; a tie counts as +1.
    function automatic logic binarise(acc_t acc, acc_t thresh);
        return acc >= thresh;
    endfunction

endpackage

// File: rtl/act_pack_if.sv
// Stream bundle between the accumulator-chain tail, act_pack and the next activation buffer.
interface act_pack_if;
    import bnn_pkg::*;

    logic start;
    logic in_valid;
    logic in_ready;
    acc_t acc_in;
    acc_t thresh_in;
    logic out_valid;
    logic out_ready;
    act_t act_out;
    logic out_last;
    logic done;

    modport master (
        output start, in_valid, acc_in, thresh_in, out_ready,
        input  in_ready, out_valid, act_out, out_last, done
    );

    modport slave (
        input  start, in_valid, acc_in, thresh_in, out_ready,
        output in_ready, out_valid, act_out, out_last, done
    );

endinterface

// File: rtl/act_out_reg.sv
// Single-entry valid/ready output register: a load always wins over a consume.
module act_out_reg
    import bnn_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  act_t load_data,
    input  logic load_last,
    input  logic ready,
    output logic valid,
    output act_t data,
    output logic last
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (valid && ready) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end
    end

endmodule

// File: rtl/act_pack.sv
// Binarises accumulator sums against per-neuron thresholds and packs the sign bits LSB-first
// into activation words for the next layer.
module act_pack
    import bnn_pkg::*;
#(
    parameter int unsigned NEURONS = 64
) (
    input logic clk,
    input logic rst,
    act_pack_if.slave bus
);

    localparam int unsigned NCW = $clog2(NEURONS + 1);
    localparam int unsigned BCW = $clog2(ACT_W);

    pack_state_t state_q, state_d;

    logic [NCW-1:0] neuron_cnt_q;
    logic [BCW-1:0] bit_cnt_q;
    act_t shift_q;

    logic accept;
    logic last_neuron;
    logic word_full;
    logic load;
    act_t word;
    logic out_valid;
    logic out_last;
    act_t act_out;
    logic final_hs;

    assign accept      = bus.in_valid & bus.in_ready;
    assign last_neuron = neuron_cnt_q == NCW'(NEURONS - 1);
    assign word_full   = bit_cnt_q == BCW'(ACT_W - 1);
    assign load        = accept & (word_full | last_neuron);
    assign word        = shift_q | (act_t'(binarise(bus.acc_in, bus.thresh_in)) << bit_cnt_q);
    assign final_hs    = out_valid & out_last & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = PACK;
            PACK:    if (accept && last_neuron) state_d = DRAIN;
            DRAIN:   if (final_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == PACK) & (~out_valid | bus.out_ready);
        bus.done     = (state_q == DRAIN) & final_hs;
    end

    // Counters and shift contents only live inside PACK; the word that completes a pass
    // leaves them cleared, so IDLE/DRAIN simply hold them at zero.
    always_ff @(posedge clk) begin
        if (rst || state_q != PACK) begin
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            neuron_cnt_q <= '0;
        end else if (accept) begin
            if (load) begin
                shift_q   <= '0;
                bit_cnt_q <= '0;
            end else begin
                shift_q   <= word;
                bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
            neuron_cnt_q <= last_neuron ? '0 : neuron_cnt_q + NCW'(1);
        end
    end

    act_out_reg u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (word),
        .load_last (last_neuron),
        .ready     (bus.out_ready),
        .valid     (out_valid),
        .data      (act_out),
        .last      (out_last)
    );

    assign bus.out_valid = out_valid;
    assign bus.act_out   = act_out;
    assign bus.out_last  = out_last;

endmodule
